// File: rtl/imm_decode_pipe.sv
// Pipelined RV32I/RV64I immediate decoder with valid/ready output stage and optional skid entry.
// Define IMM_DECODE_PIPE_CSR_EN to decode CSR immediate forms (csrr*i) as fmt 6.
module imm_decode_pipe #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
`ifdef IMM_DECODE_PIPE_CSR_EN
    localparam logic [2:0] FMT_Z = 3'd6;
`endif

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] target;
    } entry_t;

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic [2:0]         dec_fmt;
    logic               dec_illegal;
    logic signed [31:0] dec_imm32;
    logic [XLEN-1:0]    dec_imm;
    entry_t             in_entry;

    // Every immediate is first formed as a signed 32-bit value, then sign-extended to XLEN.
    always_comb begin
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        dec_imm32   = '0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (in_instr[6:0])
                OP_IMM, OP_LOAD, OP_JALR: begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = imm_i;
                end
                OP_IMM32: begin
                    if (XLEN == 64) begin
                        dec_fmt   = FMT_I;
                        dec_imm32 = imm_i;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OP_SYSTEM: begin
`ifdef IMM_DECODE_PIPE_CSR_EN
                    if (in_instr[14] && (in_instr[13:12] != 2'b00)) begin
                        dec_fmt   = FMT_Z;
                        dec_imm32 = {27'd0, in_instr[19:15]};
                    end else begin
                        dec_fmt   = FMT_I;
                        dec_imm32 = imm_i;
                    end
`else
                    dec_fmt   = FMT_I;
                    dec_imm32 = imm_i;
`endif
                end
                OP_STORE: begin
                    dec_fmt   = FMT_S;
                    dec_imm32 = imm_s;
                end
                OP_BRANCH: begin
                    dec_fmt   = FMT_B;
                    dec_imm32 = imm_b;
                end
                OP_LUI, OP_AUIPC: begin
                    dec_fmt   = FMT_U;
                    dec_imm32 = imm_u;
                end
                OP_JAL: begin
                    dec_fmt   = FMT_J;
                    dec_imm32 = imm_j;
                end
                OP_REG, OP_FENCE: begin
                    dec_fmt = FMT_R;
                end
                OP_REG32: begin
                    if (XLEN != 64) begin
                        dec_illegal = 1'b1;
                    end
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
        dec_imm = XLEN'(dec_imm32);
    end

    always_comb begin
        in_entry.instr   = in_instr;
        in_entry.pc      = in_pc;
        in_entry.imm     = dec_imm;
        in_entry.fmt     = dec_fmt;
        in_entry.illegal = dec_illegal;
        in_entry.target  = in_pc + dec_imm;
    end

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q, ready_d;
    logic   in_fire;
    logic   out_fire;

    // ready_q is low through reset, so in_ready stays low until the first edge with rstn high.
    assign in_ready = (SKID != 0) ? ready_q : (ready_q && (!main_valid_q || out_ready));
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (!main_valid_q || out_fire) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (in_fire) begin
                    main_d       = in_entry;
                    main_valid_d = 1'b1;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end else begin
            if (in_fire) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else if (out_fire) begin
                main_valid_d = 1'b0;
            end
        end
        ready_d = (SKID != 0) ? !skid_valid_d : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_target  = main_q.target;

endmodule
